dcache_l2_nway: RTL
===================

Name: dcache_l2_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L2 data cache between the L1/processor side and main memory.
- Successor to the fixed 2-way, 16-set L2. Generalised in way count, set count, line width and address width.
- Adds round-robin victim selection with invalid-way preference, a full-cache flush (write back all dirty lines), and hit/miss event counters.

Parameters:
ADDR_W, 28, line address width (proc_addr / mem_addr)
DATA_W, 128, line width in bits
SET_OFFSET, 4, set index bits; NUM_SET = 2**SET_OFFSET
NUM_WAY, 4, associativity; power of two, 2..8
CNT_W, 32, width of hit/miss counters

Ports:
clk  in  1  clock, all state updates on rising edge
proc_reset_n  in  1  synchronous, active-low reset
proc_read  in  1  read request, held until proc_ready
proc_write  in  1  write request, held until proc_ready
proc_addr  in  ADDR_W  line address; tag = [ADDR_W-1:SET_OFFSET], set = [SET_OFFSET-1:0]
proc_wdata  in  DATA_W  full-line write data
proc_ready  out  1  access complete this cycle
proc_rdata  out  DATA_W  read data, valid when proc_ready && proc_read
flush  in  1  flush request, level, sampled in IDLE only
flush_done  out  1  one-cycle pulse when flush finishes
mem_read  out  1  memory line read request
mem_write  out  1  memory line write request
mem_addr  out  ADDR_W  memory line address
mem_wdata  out  DATA_W  write-back data
mem_rdata  in  DATA_W  fill data, valid with mem_ready
mem_ready  in  1  memory transaction complete this cycle
hit_cnt  out  CNT_W  completed hits, wraps
miss_cnt  out  CNT_W  detected misses, wraps

Behaviour:
- Reset: on a clk edge with proc_reset_n=0, clear all valid/dirty/tag/data, rr_ptr[*]=0, counters=0, state=IDLE, flush index=0.
- While proc_reset_n=0, force every output to 0.
- Reset mid-miss or mid-flush abandons the operation. No write-back occurs.
- Request decode: read = proc_read&~proc_write; write = proc_write&~proc_read. Both or neither means no access, and proc_ready stays 0.
- Outputs are combinational from state and inputs. Defaults are 0.
- mem_read/mem_write/mem_addr/mem_wdata are held stable until the cycle mem_ready=1. That cycle completes the memory transaction; the request is dropped or changed the next cycle.
- Hit: tag match on any valid way in IDLE gives proc_ready=1 in the same cycle (0-cycle latency).
  - Read hit: proc_rdata = way data.
  - Write hit: update data, set dirty.
  - hit_cnt += 1.
- Victim selection: lowest-index invalid way if any; otherwise way rr_ptr[set]. rr_ptr[set] increments mod NUM_WAY only when a valid way is evicted.
- Miss: miss_cnt += 1 in the IDLE detection cycle (once per access).
  - Victim dirty: go to WB; mem_write with {victim tag,set}, victim data.
  - Read miss, clean victim: go to FILL; mem_read with proc_addr.
  - Write miss, clean victim: install proc_wdata (valid=1, dirty=1, new tag), proc_ready=1 that cycle, stay IDLE.
- States:
  - IDLE: as above. If flush=1 and no access is decoded, go to FLUSH.
  - WB: on mem_ready, clear victim dirty. For a read, go to FILL and issue mem_read the next cycle. For a write, install proc_wdata dirty, proc_ready=1 in that cycle, go to IDLE.
  - FILL: on mem_ready, install mem_rdata (valid=1, dirty=0), proc_rdata = mem_rdata, proc_ready=1, go to IDLE.
  - FLUSH: scan index = {set,way} from 0 to NUM_SET*NUM_WAY-1, one entry per cycle.
    - Valid&dirty entry: go to FLUSH_WB.
    - Other entries are skipped.
    - After the last index: flush_done=1 for one cycle, index=0, go to IDLE.
  - FLUSH_WB: mem_write with {tag,set}, data. On mem_ready, clear dirty (line stays valid), advance the index, return to FLUSH. Past the last index, pulse flush_done and go to IDLE.
- Processor requests are not serviced (proc_ready=0) during FLUSH/FLUSH_WB.
- mem_ready outside a pending transaction is ignored.
- Counters wrap at 2**CNT_W.

Test Plan:
- Reset, then read 0x0000010 → miss, FILL; mem returns 0xA5..A5 → proc_ready with rdata 0xA5..A5. Repeat the read → 0-cycle hit; hit_cnt=1, miss_cnt=1.
- Write tags 1..4 to set 3 (4 ways, clean misses, no mem traffic), then write tag 5 → victim way 0 (rr_ptr=0) dirty: mem_write at addr {tag1,3}, then install; rr_ptr[3]=1.
- Read miss in set 3 with dirty victim → mem_write, mem_ready after 3 cycles, then mem_read, proc_ready only on the fill mem_ready. Verify that mem_addr/mem_wdata stay stable while waiting.
- Dirty lines at (set0,way1) and (set15,way3), then flush → exactly two mem_writes in index order, flush_done one pulse, lines still hit afterwards with dirty=0.
- Assert proc_reset_n=0 during WB → next cycle all outputs 0 and state IDLE. A subsequent read of the previously cached line misses.
- proc_read=proc_write=1 → no proc_ready, no memory traffic, counters unchanged.

Source files
------------

// File: rtl/dcache_l2_nway.sv
// dcache_l2_nway: N-way set-associative write-back/write-allocate L2 data cache
// with round-robin victims (invalid ways first), full flush and hit/miss counters.
module dcache_l2_nway #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int SET_OFFSET = 4,
  parameter int NUM_WAY    = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_ready,
  output logic [DATA_W-1:0] proc_rdata,
  input  logic              flush,
  output logic              flush_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int TAG_W   = ADDR_W - SET_OFFSET;
  localparam int NUM_SET = 2 ** SET_OFFSET;
  localparam int WAY_W   = $clog2(NUM_WAY);
  localparam int IDX_W   = SET_OFFSET + WAY_W;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, FLUSH_WB} state_t;
  state_t state, state_d;

  logic [NUM_SET-1:0][NUM_WAY-1:0]             valid_q, dirty_q;
  logic [NUM_SET-1:0][NUM_WAY-1:0][TAG_W-1:0]  tag_q;
  logic [NUM_SET-1:0][NUM_WAY-1:0][DATA_W-1:0] data_q;
  logic [NUM_SET-1:0][WAY_W-1:0]               rr_q;
  logic [WAY_W-1:0]  vic_q, vic_d, vic, hit_way, inv_way, w_way, c_way;
  logic [IDX_W-1:0]  fidx, fidx_d;
  logic [CNT_W-1:0]  hit_q, miss_q;
  logic [SET_OFFSET-1:0] set, fset, c_set;
  logic [WAY_W-1:0]  fway;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] w_data;
  logic rd, wr, hit, inv, wen, w_dirty, dclr, rr_inc, hit_inc, miss_inc;

  assign rd       = proc_read & ~proc_write;
  assign wr       = proc_write & ~proc_read;
  assign set      = proc_addr[SET_OFFSET-1:0];
  assign tag      = proc_addr[ADDR_W-1:SET_OFFSET];
  assign fset     = fidx[IDX_W-1:WAY_W];
  assign fway     = fidx[WAY_W-1:0];
  assign vic      = inv ? inv_way : rr_q[set];
  assign hit_cnt  = proc_reset_n ? hit_q : '0;
  assign miss_cnt = proc_reset_n ? miss_q : '0;

  // descending scan so the lowest matching/invalid way wins
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv     = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      if (valid_q[set][w] && tag_q[set][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set][w]) begin
        inv     = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d    = state;
    vic_d      = vic_q;
    fidx_d     = fidx;
    proc_ready = 1'b0;
    proc_rdata = '0;
    flush_done = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wen        = 1'b0;
    w_way      = vic_q;
    w_data     = proc_wdata;
    w_dirty    = 1'b1;
    dclr       = 1'b0;
    c_set      = set;
    c_way      = vic_q;
    rr_inc     = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    if (proc_reset_n) begin
      case (state)
        IDLE: begin
          if ((rd | wr) && hit) begin
            proc_ready = 1'b1;
            proc_rdata = data_q[set][hit_way];
            hit_inc    = 1'b1;
            wen        = wr;
            w_way      = hit_way;
          end else if (rd | wr) begin
            miss_inc = 1'b1;
            vic_d    = vic;
            rr_inc   = ~inv;
            if (valid_q[set][vic] && dirty_q[set][vic]) state_d = WB;
            else if (rd) state_d = FILL;
            else begin
              wen        = 1'b1;
              w_way      = vic;
              proc_ready = 1'b1;
            end
          end else if (flush) state_d = FLUSH;
        end
        WB: begin
          mem_write = 1'b1;
          mem_addr  = {tag_q[set][vic_q], set};
          mem_wdata = data_q[set][vic_q];
          if (mem_ready) begin
            dclr       = 1'b1;
            wen        = wr;
            proc_ready = wr;
            state_d    = rd ? FILL : IDLE;
          end
        end
        FILL: begin
          mem_read = 1'b1;
          mem_addr = proc_addr;
          if (mem_ready) begin
            wen        = 1'b1;
            w_data     = mem_rdata;
            w_dirty    = 1'b0;
            proc_rdata = mem_rdata;
            proc_ready = 1'b1;
            state_d    = IDLE;
          end
        end
        FLUSH: begin
          if (valid_q[fset][fway] && dirty_q[fset][fway]) state_d = FLUSH_WB;
          else begin
            fidx_d     = fidx + 1'b1;
            flush_done = &fidx;
            state_d    = (&fidx) ? IDLE : FLUSH;
          end
        end
        FLUSH_WB: begin
          mem_write = 1'b1;
          mem_addr  = {tag_q[fset][fway], fset};
          mem_wdata = data_q[fset][fway];
          if (mem_ready) begin
            dclr       = 1'b1;
            c_set      = fset;
            c_way      = fway;
            fidx_d     = fidx + 1'b1;
            flush_done = &fidx;
            state_d    = (&fidx) ? IDLE : FLUSH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state   <= IDLE;
      vic_q   <= '0;
      fidx    <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      rr_q    <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state  <= state_d;
      vic_q  <= vic_d;
      fidx   <= fidx_d;
      if (rr_inc) rr_q[set] <= rr_q[set] + 1'b1;
      if (hit_inc) hit_q <= hit_q + 1'b1;
      if (miss_inc) miss_q <= miss_q + 1'b1;
      if (dclr) dirty_q[c_set][c_way] <= 1'b0;
      // an install after a write-back reuses the same way, so it overrides the clear
      if (wen) begin
        valid_q[set][w_way] <= 1'b1;
        dirty_q[set][w_way] <= w_dirty;
        tag_q[set][w_way]   <= tag;
        data_q[set][w_way]  <= w_data;
      end
    end
  end
endmodule
